eth_irq_coalesce: RTL and testbench

ETH_IRQ_COALESCE -- requirements
Module: eth_irq_coalesce

---
 rtl/eth_irq_coalesce.sv | 133 +++++++++++++
 tb/tb_eth_irq_coalesce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_irq_coalesce.sv
// Ethernet/DMA interrupt coalescer: it collects completion events and raises one level interrupt on a count threshold or a timeout.
// Optional statistics counter irq_count_o is enabled by defining ETH_IRQ_COAL_STATS_EN.
module eth_irq_coalesce #(
    parameter int CntWidth   = 8,
    parameter int TimerWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  event_i,
    input  logic [CntWidth-1:0]   cnt_thresh_i,
    input  logic [TimerWidth-1:0] timeout_i,
    input  logic                  irq_ack_i,
    output logic                  irq_o,
    output logic [CntWidth-1:0]   pending_cnt_o,
    output logic [31:0]           irq_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } state_t;

    localparam logic [CntWidth-1:0]   CNT_ONE = CntWidth'(1);
    localparam logic [CntWidth-1:0]   CNT_MAX = {CntWidth{1'b1}};
    localparam logic [TimerWidth-1:0] TMR_MAX = {TimerWidth{1'b1}};

    state_t                  state_reg, state_next;
    logic [CntWidth-1:0]     pending_reg, pending_next;
    logic [TimerWidth-1:0]   timer_reg, timer_next;
    logic                    irq_reg;

    logic [CntWidth-1:0]     thresh_eff;
    logic [CntWidth:0]       pending_sum;
    logic [CntWidth-1:0]     pending_sat;
    logic [TimerWidth:0]     timer_sum;
    logic [TimerWidth-1:0]   timer_sat;
    logic                    fresh_fire;
    logic                    count_hit;
    logic                    time_hit;

    // Sums are one bit wider so that threshold and timeout compares never wrap.
    always_comb begin
        thresh_eff  = (cnt_thresh_i == '0) ? CNT_ONE : cnt_thresh_i;
        pending_sum = {1'b0, pending_reg} + {{CntWidth{1'b0}}, event_i};
        pending_sat = pending_sum[CntWidth] ? CNT_MAX : pending_sum[CntWidth-1:0];
        timer_sum   = {1'b0, timer_reg} + {{TimerWidth{1'b0}}, 1'b1};
        timer_sat   = timer_sum[TimerWidth] ? TMR_MAX : timer_sum[TimerWidth-1:0];
        fresh_fire  = !en_i || (thresh_eff == CNT_ONE);
        count_hit   = pending_sum >= {1'b0, thresh_eff};
        time_hit    = (timeout_i != '0) && (timer_sum >= {1'b0, timeout_i});
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        timer_next   = timer_reg;
        case (state_reg)
            IDLE: begin
                if (event_i) begin
                    pending_next = CNT_ONE;
                    timer_next   = '0;
                    state_next   = fresh_fire ? FIRE : ACCUM;
                end
            end
            ACCUM: begin
                pending_next = pending_sat;
                timer_next   = timer_sat;
                if (!en_i || count_hit || time_hit) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                pending_next = pending_sat;
                if (irq_ack_i) begin
                    timer_next = '0;
                    if (event_i) begin
                        // An event arriving with the ack opens a fresh window.
                        pending_next = CNT_ONE;
                        state_next   = fresh_fire ? FIRE : ACCUM;
                    end else begin
                        pending_next = '0;
                        state_next   = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
                timer_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            timer_reg   <= '0;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            timer_reg   <= timer_next;
            irq_reg     <= (state_next == FIRE);
        end
    end

    assign irq_o         = irq_reg;
    assign pending_cnt_o = pending_reg;

`ifdef ETH_IRQ_COAL_STATS_EN
    logic [31:0] irq_count_reg;
    logic        fire_entry;

    // FIRE re-entered straight from FIRE never dropped irq_o, so it is not a new assertion.
    assign fire_entry = (state_reg != FIRE) && (state_next == FIRE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_count_reg <= '0;
        end else if (fire_entry) begin
            irq_count_reg <= irq_count_reg + 32'd1;
        end
    end

    assign irq_count_o = irq_count_reg;
`else
    assign irq_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_eth_irq_coalesce.sv
// Directed self-checking bench for eth_irq_coalesce; expected values are hand-derived per scenario.
// The irq_count_o expectations follow ETH_IRQ_COAL_STATS_EN when it is defined for the build.
module tb_eth_irq_coalesce;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        event_i = 1'b0;
    logic [7:0]  cnt_thresh_i = 8'd1;
    logic [15:0] timeout_i = 16'd0;
    logic        irq_ack_i = 1'b0;
    logic        irq_o;
    logic [7:0]  pending_cnt_o;
    logic [31:0] irq_count_o;

    int checks = 0;
    int failures = 0;

    eth_irq_coalesce #(.CntWidth(8), .TimerWidth(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .event_i       (event_i),
        .cnt_thresh_i  (cnt_thresh_i),
        .timeout_i     (timeout_i),
        .irq_ack_i     (irq_ack_i),
        .irq_o         (irq_o),
        .pending_cnt_o (pending_cnt_o),
        .irq_count_o   (irq_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef ETH_IRQ_COAL_STATS_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_event();
        event_i = 1'b1;
        tick();
        event_i = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state while rst_ni is held low.
        #12;
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_pending", 32'(pending_cnt_o), 32'd0);
        check("rst_count", irq_count_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Per-event mode: irq one cycle after the event, held until ack.
        en_i = 1'b0;
        repeat (10) tick();
        check("pe_idle_irq", 32'(irq_o), 32'd0);
        pulse_event();
        check("pe_irq_rise", 32'(irq_o), 32'd1);
        check("pe_pending", 32'(pending_cnt_o), 32'd1);
        repeat (8) tick();
        check("pe_irq_held", 32'(irq_o), 32'd1);
        pulse_ack();
        check("pe_irq_ack", 32'(irq_o), 32'd0);
        check("pe_pending_ack", 32'(pending_cnt_o), 32'd0);
        check("pe_count", irq_count_o, exp_cnt(1));

        // Count threshold 4, events at relative cycles 0,5,9,30.
        en_i = 1'b1;
        cnt_thresh_i = 8'd4;
        timeout_i = 16'd0;
        for (int c = 0; c <= 30; c++) begin
            event_i = (c == 0 || c == 5 || c == 9 || c == 30);
            tick();
            event_i = 1'b0;
            if (c == 29) begin
                check("th_irq_before", 32'(irq_o), 32'd0);
                check("th_pending_before", 32'(pending_cnt_o), 32'd3);
            end
        end
        check("th_irq_fire", 32'(irq_o), 32'd1);
        check("th_pending_fire", 32'(pending_cnt_o), 32'd4);
        check("th_count", irq_count_o, exp_cnt(2));
        pulse_ack();
        check("th_irq_ack", 32'(irq_o), 32'd0);

        // Timeout 50: event at edge E fires at edge E+50.
        cnt_thresh_i = 8'd10;
        timeout_i = 16'd50;
        pulse_event();
        repeat (49) tick();
        check("to_irq_before", 32'(irq_o), 32'd0);
        tick();
        check("to_irq_fire", 32'(irq_o), 32'd1);
        check("to_pending", 32'(pending_cnt_o), 32'd1);
        check("to_count", irq_count_o, exp_cnt(3));
        pulse_ack();

        // Ack ignored in ACCUM, then live lowering of threshold fires next cycle.
        timeout_i = 16'd0;
        repeat (3) pulse_event();
        pulse_ack();
        check("accum_ack_irq", 32'(irq_o), 32'd0);
        check("accum_ack_pending", 32'(pending_cnt_o), 32'd3);
        cnt_thresh_i = 8'd3;
        tick();
        check("live_th_irq", 32'(irq_o), 32'd1);
        check("live_th_count", irq_count_o, exp_cnt(4));
        pulse_ack();

        // Threshold 0 acts as 1.
        cnt_thresh_i = 8'd0;
        pulse_event();
        check("th0_irq", 32'(irq_o), 32'd1);
        check("th0_count", irq_count_o, exp_cnt(5));

        // Ack and event together in FIRE with threshold 2: back to ACCUM holding one event.
        cnt_thresh_i = 8'd2;
        irq_ack_i = 1'b1;
        event_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        event_i = 1'b0;
        check("ackev_irq", 32'(irq_o), 32'd0);
        check("ackev_pending", 32'(pending_cnt_o), 32'd1);
        pulse_event();
        check("ackev_irq2", 32'(irq_o), 32'd1);
        check("ackev_pending2", 32'(pending_cnt_o), 32'd2);
        check("ackev_count", irq_count_o, exp_cnt(6));
        pulse_ack();

        // Saturation with threshold 255 over 300 back-to-back events.
        cnt_thresh_i = 8'hFF;
        event_i = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 254) begin
                check("sat_irq_254", 32'(irq_o), 32'd0);
                check("sat_pending_254", 32'(pending_cnt_o), 32'd254);
            end
            if (n == 255) check("sat_irq_255", 32'(irq_o), 32'd1);
        end
        event_i = 1'b0;
        check("sat_pending_300", 32'(pending_cnt_o), 32'd255);
        check("sat_irq_300", 32'(irq_o), 32'd1);
        check("sat_count", irq_count_o, exp_cnt(7));

        // Asynchronous reset mid-FIRE, observed before the next clock edge.
        rst_ni = 1'b0;
        #2;
        check("arst_irq", 32'(irq_o), 32'd0);
        check("arst_pending", 32'(pending_cnt_o), 32'd0);
        check("arst_count", irq_count_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (5) tick();
        check("post_rst_irq", 32'(irq_o), 32'd0);
        check("post_rst_pending", 32'(pending_cnt_o), 32'd0);

        // Three fire/ack rounds in per-event mode.
        en_i = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            pulse_event();
            check("stat_irq", 32'(irq_o), 32'd1);
            pulse_ack();
            check("stat_count", irq_count_o, exp_cnt(r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
